// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I sequencer: steps the datapath through fetch/decode/execute/memory/writeback
// and handshakes the data bus with a bounded wait.
`timescale 1ns/1ps
module multi_cycle_control_unit #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        btaken,
  input  logic        busReady,
  output logic        irWe,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        RD1MuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic        busRe,
  output logic        illegalInstr,
  output logic        busErr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, L_EXE, L_MEM, L_WB, S_EXE, S_MEM,
    B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inputs;

  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];
  assign unused_inputs = ^{btaken, instrCode[31], instrCode[29:15], instrCode[11:7]};

  function automatic logic known_opcode(input logic [6:0] op);
    return (op == OP_R) || (op == OP_L) || (op == OP_I) || (op == OP_S) || (op == OP_B) ||
           (op == OP_LU) || (op == OP_AU) || (op == OP_J) || (op == OP_JL);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      tmo_cnt <= '0;
      busErr  <= 1'b0;
    end else begin
      busErr <= 1'b0;
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:    state <= R_EXE;
            OP_L:    state <= L_EXE;
            OP_I:    state <= I_EXE;
            OP_S:    state <= S_EXE;
            OP_B:    state <= B_EXE;
            OP_LU:   state <= LU_EXE;
            OP_AU:   state <= AU_EXE;
            OP_J:    state <= J_EXE;
            OP_JL:   state <= JL_EXE;
            default: state <= FETCH;
          endcase
        end
        L_EXE: begin
          state   <= L_MEM;
          tmo_cnt <= '0;
        end
        S_EXE: begin
          state   <= S_MEM;
          tmo_cnt <= '0;
        end
        L_MEM, S_MEM: begin
          // A ready bus always wins over the timeout in the same cycle.
          if (busReady) begin
            state   <= (state == L_MEM) ? L_WB : FETCH;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= FETCH;
            tmo_cnt <= '0;
            busErr  <= 1'b1;
          end else begin
            tmo_cnt <= 8'(tmo_cnt + 8'd1);
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs follow the state; reset low forces every one of them to zero at once.
  always_comb begin
    irWe          = 1'b0;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    RD1MuxSel     = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busWe         = 1'b0;
    busRe         = 1'b0;
    illegalInstr  = 1'b0;
    if (reset) begin
      case (state)
        FETCH:  irWe = 1'b1;
        DECODE: begin
          if (!known_opcode(opcode)) begin
            illegalInstr = 1'b1;
            PCEn         = 1'b1;
          end
        end
        R_EXE: begin
          aluControl = {instrCode[30], funct3};
          regFileWe  = 1'b1;
          PCEn       = 1'b1;
        end
        I_EXE: begin
          // Only the shift-right pair uses bit 30 to pick arithmetic vs logical.
          aluControl   = (funct3 == 3'b101) ? {instrCode[30], funct3} : {1'b0, funct3};
          aluSrcMuxSel = 1'b1;
          regFileWe    = 1'b1;
          PCEn         = 1'b1;
        end
        L_EXE, S_EXE: aluSrcMuxSel = 1'b1;
        L_MEM: begin
          aluSrcMuxSel = 1'b1;
          busRe        = 1'b1;
        end
        L_WB: begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 3'b001;
          PCEn          = 1'b1;
        end
        S_MEM: begin
          aluSrcMuxSel = 1'b1;
          busWe        = 1'b1;
          PCEn         = busReady;
        end
        B_EXE: begin
          aluControl = {instrCode[30], funct3};
          branch     = 1'b1;
          PCEn       = 1'b1;
        end
        LU_EXE: begin
          regFileWe     = 1'b1;
          aluSrcMuxSel  = 1'b1;
          RD1MuxSel     = 1'b1;
          RFWDSrcMuxSel = 3'b010;
          PCEn          = 1'b1;
        end
        AU_EXE: begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 3'b011;
          PCEn          = 1'b1;
        end
        J_EXE: begin
          jal           = 1'b1;
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 3'b100;
          PCEn          = 1'b1;
        end
        JL_EXE: begin
          jalr          = 1'b1;
          aluSrcMuxSel  = 1'b1;
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 3'b100;
          PCEn          = 1'b1;
        end
        default: irWe = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: driver queues the expected control word per cycle,
// a negedge monitor pops and compares it against the DUT.
`timescale 1ns/1ps
module tb_multi_cycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrCode = 32'h0;
  logic        btaken = 1'b0;
  logic        busReady = 1'b0;
  logic        irWe, PCEn, regFileWe, aluSrcMuxSel, RD1MuxSel;
  logic        branch, jal, jalr, busWe, busRe, illegalInstr, busErr;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;

  multi_cycle_control_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .btaken(btaken), .busReady(busReady),
    .irWe(irWe), .PCEn(PCEn), .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .RFWDSrcMuxSel(RFWDSrcMuxSel), .RD1MuxSel(RD1MuxSel),
    .branch(branch), .jal(jal), .jalr(jalr), .busWe(busWe), .busRe(busRe),
    .illegalInstr(illegalInstr), .busErr(busErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [18:0] exp;
  } item_t;

  item_t       sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [18:0] act;

  // Bit order: irWe PCEn regFileWe aluControl[4] aluSrc RFWDSrc[3] RD1 branch jal jalr busWe busRe illegal busErr
  assign act = {irWe, PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, RD1MuxSel,
                branch, jal, jalr, busWe, busRe, illegalInstr, busErr};

  function automatic logic [18:0] ev(input logic irwe, pcen, rfwe, input logic [3:0] alu,
                                     input logic asrc, input logic [2:0] wd,
                                     input logic rd1, br, j, jr, bwe, bre, ill, berr);
    return {irwe, pcen, rfwe, alu, asrc, wd, rd1, br, j, jr, bwe, bre, ill, berr};
  endfunction

  task automatic check(input string nm, input logic [18:0] a, input logic [18:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      check(it.nm, act, it.exp);
    end
  end

  task automatic cyc(input string nm, input logic br, input logic [18:0] e);
    item_t it;
    busReady = br;
    it.nm  = nm;
    it.exp = e;
    sbq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [18:0] e_f, e_fe, e_d, e_add, e_sub, e_xexe, e_lmem, e_lwb, e_sw, e_sr;
    logic [18:0] e_lui, e_srai, e_addi, e_ill, e_bne, e_jal, e_jalr, e_aui;
    e_f    = ev(1,0,0,4'b0000,0,3'b000,0,0,0,0,0,0,0,0);
    e_fe   = ev(1,0,0,4'b0000,0,3'b000,0,0,0,0,0,0,0,1);
    e_d    = ev(0,0,0,4'b0000,0,3'b000,0,0,0,0,0,0,0,0);
    e_add  = ev(0,1,1,4'b0000,0,3'b000,0,0,0,0,0,0,0,0);
    e_sub  = ev(0,1,1,4'b1000,0,3'b000,0,0,0,0,0,0,0,0);
    e_xexe = ev(0,0,0,4'b0000,1,3'b000,0,0,0,0,0,0,0,0);
    e_lmem = ev(0,0,0,4'b0000,1,3'b000,0,0,0,0,0,1,0,0);
    e_lwb  = ev(0,1,1,4'b0000,0,3'b001,0,0,0,0,0,0,0,0);
    e_sw   = ev(0,0,0,4'b0000,1,3'b000,0,0,0,0,1,0,0,0);
    e_sr   = ev(0,1,0,4'b0000,1,3'b000,0,0,0,0,1,0,0,0);
    e_lui  = ev(0,1,1,4'b0000,1,3'b010,1,0,0,0,0,0,0,0);
    e_srai = ev(0,1,1,4'b1101,1,3'b000,0,0,0,0,0,0,0,0);
    e_addi = ev(0,1,1,4'b0000,1,3'b000,0,0,0,0,0,0,0,0);
    e_ill  = ev(0,1,0,4'b0000,0,3'b000,0,0,0,0,0,0,1,0);
    e_bne  = ev(0,1,0,4'b0001,0,3'b000,0,1,0,0,0,0,0,0);
    e_jal  = ev(0,1,1,4'b0000,0,3'b100,0,0,1,0,0,0,0,0);
    e_jalr = ev(0,1,1,4'b0000,1,3'b100,0,0,0,1,0,0,0,0);
    e_aui  = ev(0,1,1,4'b0000,0,3'b011,0,0,0,0,0,0,0,0);

    #1 reset = 1'b0;
    #2 check("reset_outputs", act, 19'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    instrCode = 32'h002081B3;
    cyc("add_fetch", 0, e_f); cyc("add_decode", 0, e_d); cyc("add_exe", 1, e_add);
    instrCode = 32'h402081B3;
    cyc("sub_fetch", 0, e_f); cyc("sub_decode", 0, e_d); cyc("sub_exe", 0, e_sub);

    instrCode = 32'h0000A183;
    cyc("lw_fetch", 0, e_f); cyc("lw_decode", 0, e_d); cyc("lw_exe", 0, e_xexe);
    cyc("lw_mem0", 0, e_lmem); cyc("lw_mem1", 0, e_lmem); cyc("lw_mem2", 1, e_lmem);
    cyc("lw_wb", 0, e_lwb);

    instrCode = 32'h0020A023;
    cyc("sw_fetch", 0, e_f); cyc("sw_decode", 0, e_d); cyc("sw_exe", 0, e_xexe);
    for (int i = 0; i < 4; i++) cyc($sformatf("sw_wait%0d", i), 0, e_sw);
    cyc("sw_abort_fetch", 0, e_fe); cyc("sw_retry_decode", 0, e_d);
    cyc("sw_retry_exe", 0, e_xexe); cyc("sw_retry_ready", 1, e_sr);

    cyc("swb_fetch", 0, e_f); cyc("swb_decode", 0, e_d); cyc("swb_exe", 0, e_xexe);
    for (int i = 0; i < 3; i++) cyc($sformatf("swb_wait%0d", i), 0, e_sw);
    cyc("swb_ready_at_limit", 1, e_sr);

    instrCode = 32'h123452B7;
    cyc("lui_fetch_no_err", 0, e_f); cyc("lui_decode", 0, e_d); cyc("lui_exe", 0, e_lui);
    instrCode = 32'h4010D093;
    cyc("srai_fetch", 0, e_f); cyc("srai_decode", 0, e_d); cyc("srai_exe", 0, e_srai);
    instrCode = 32'h40008093;
    cyc("addi30_fetch", 0, e_f); cyc("addi30_decode", 0, e_d); cyc("addi30_exe", 0, e_addi);
    instrCode = 32'h00209463;
    btaken = 1'b1;
    cyc("bne_fetch", 0, e_f); cyc("bne_decode", 0, e_d); cyc("bne_exe", 0, e_bne);
    btaken = 1'b0;
    instrCode = 32'h008000EF;
    cyc("jal_fetch", 0, e_f); cyc("jal_decode", 0, e_d); cyc("jal_exe", 0, e_jal);
    instrCode = 32'h000080E7;
    cyc("jalr_fetch", 0, e_f); cyc("jalr_decode", 0, e_d); cyc("jalr_exe", 0, e_jalr);
    instrCode = 32'h00001097;
    cyc("auipc_fetch", 0, e_f); cyc("auipc_decode", 0, e_d); cyc("auipc_exe", 0, e_aui);
    instrCode = 32'h0000007F;
    cyc("ill_fetch", 0, e_f); cyc("ill_decode", 1, e_ill);

    instrCode = 32'h0000A183;
    cyc("rlw_fetch", 0, e_f); cyc("rlw_decode", 0, e_d); cyc("rlw_exe", 0, e_xexe);
    cyc("rlw_mem0", 0, e_lmem);
    busReady = 1'b0;
    #1 check("busRe_before_reset", {18'd0, busRe}, 19'd1);
    reset = 1'b0;
    #1 check("reset_async_mid_mem", act, 19'd0);
    @(posedge clk);
    #1 check("reset_held_over_edge", act, 19'd0);
    reset = 1'b1;
    cyc("post_reset_fetch", 0, e_f); cyc("post_reset_decode", 0, e_d);
    cyc("post_reset_exe", 0, e_xexe); cyc("post_reset_mem", 1, e_lmem);
    cyc("post_reset_wb", 0, e_lwb); cyc("final_fetch", 0, e_f);

    @(negedge clk);
    #1 check("scoreboard_drained", 19'(sbq.size()), 19'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
